// File: rtl/bcd2_to_bin_conv_pkg.sv
// bcd2_to_bin_conv_pkg: shared state encoding and constants for the BCD-to-binary converter.
// Revision: 1.0
`default_nettype none

package bcd2_to_bin_conv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ADD2  = 3'd2,
        ADD0  = 3'd3,
        RANGE = 3'd4
    } bcd2_state_t;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam int         BCD2_ACC_W    = 7;

    // Preload limits for the seconds/minutes counters and the hours counter.
    localparam int MAX_VAL_SEC_MIN = 59;
    localparam int MAX_VAL_HOURS   = 23;

endpackage

`default_nettype wire

// File: rtl/bcd2_to_bin_conv_if.sv
// bcd2_to_bin_conv_if: start/done handshake between a BCD source and the converter.
// Revision: 1.0
`default_nettype none

interface bcd2_to_bin_conv_if #(
    parameter int N = 6
);
    logic         start;
    logic [3:0]   digit1;
    logic [3:0]   digit0;
    logic         busy;
    logic         done;
    logic [N-1:0] bin_out;
    logic         err;

    modport master (
        output start, digit1, digit0,
        input  busy, done, bin_out, err
    );

    modport slave (
        input  start, digit1, digit0,
        output busy, done, bin_out, err
    );
endinterface

`default_nettype wire

// File: rtl/bcd2_to_bin_conv_bcd_nibble_check.sv
// bcd_nibble_check: flags whether a 4-bit nibble is a legal BCD digit (0-9).
// Revision: 1.0
`default_nettype none

module bcd_nibble_check
    import bcd2_to_bin_conv_pkg::*;
(
    input  logic [3:0] nibble,
    output logic       valid
);
    assign valid = (nibble <= BCD_DIGIT_MAX);
endmodule

`default_nettype wire

// File: rtl/bcd2_to_bin_conv.sv
// bcd2_to_bin_conv: 4-clock sequential two-digit BCD-to-binary converter with range flagging.
// Build option BCD_SATURATE_EN clamps out-of-range results to MAX_VAL instead of 0. Revision: 1.0
`default_nettype none

module bcd2_to_bin_conv
    import bcd2_to_bin_conv_pkg::*;
#(
    parameter int N       = 6,
    parameter int MAX_VAL = MAX_VAL_SEC_MIN
) (
    input  logic                  clk,
    input  logic                  reset,
    bcd2_to_bin_conv_if.slave     bus
);
    localparam logic [BCD2_ACC_W-1:0] MAX_ACC = BCD2_ACC_W'(MAX_VAL);

    bcd2_state_t           state, state_next;
    logic [BCD2_ACC_W-1:0] acc, acc_next;
    logic [3:0]            d1, d1_next;
    logic [3:0]            d0, d0_next;
    logic [N-1:0]          bin_q, bin_next;
    logic                  err_q, err_next;
    logic                  done_q, done_next;
    logic                  d1_ok, d0_ok;

    bcd_nibble_check u_chk_d1 (.nibble(d1), .valid(d1_ok));
    bcd_nibble_check u_chk_d0 (.nibble(d0), .valid(d0_ok));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            d1     <= '0;
            d0     <= '0;
            bin_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            acc    <= acc_next;
            d1     <= d1_next;
            d0     <= d0_next;
            bin_q  <= bin_next;
            err_q  <= err_next;
            done_q <= done_next;
        end
    end

    // acc = d1*8 + d1*2 + d0, built across ADD2/ADD0 so no multiplier is needed.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        d1_next    = d1;
        d0_next    = d0;
        bin_next   = bin_q;
        err_next   = err_q;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    d1_next    = bus.digit1;
                    d0_next    = bus.digit0;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (!(d1_ok && d0_ok)) begin
                    bin_next   = '0;
                    err_next   = 1'b1;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    acc_next   = {d1, 3'b000};
                    state_next = ADD2;
                end
            end
            ADD2: begin
                acc_next   = acc + {2'b00, d1, 1'b0};
                state_next = ADD0;
            end
            ADD0: begin
                acc_next   = acc + {3'b000, d0};
                state_next = RANGE;
            end
            RANGE: begin
                if (acc <= MAX_ACC) begin
                    bin_next = acc[N-1:0];
                    err_next = 1'b0;
                end else begin
`ifdef BCD_SATURATE_EN
                    bin_next = N'(MAX_VAL);
`else
                    bin_next = '0;
`endif
                    err_next = 1'b1;
                end
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_q;
    assign bus.bin_out = bin_q;
    assign bus.err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd2_to_bin_conv.sv
// tb_bcd2_to_bin_conv: directed and random checks of the converter against an arithmetic model.
// Revision: 1.0
`default_nettype none

module tb_bcd2_to_bin_conv;
    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    bcd2_to_bin_conv_if #(.N(6)) bus ();

    bcd2_to_bin_conv #(.N(6), .MAX_VAL(59)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: value = tens*10 + units, judged against the 0..59 window.
    function automatic void model(input logic [3:0] a, input logic [3:0] b,
                                  output logic [5:0] bin, output logic e, output int lat);
        int v;
        if (a > 9 || b > 9) begin
            bin = 6'd0; e = 1'b1; lat = 1;
        end else begin
            v = int'(a) * 10 + int'(b);
            lat = 4;
            if (v <= 59) begin
                bin = 6'(v); e = 1'b0;
            end else begin
`ifdef BCD_SATURATE_EN
                bin = 6'd59;
`else
                bin = 6'd0;
`endif
                e = 1'b1;
            end
        end
    endfunction

    task automatic convert(input logic [3:0] a, input logic [3:0] b, input string tag);
        logic [5:0] eb;
        logic       ee;
        int         elat;
        int         lat;
        int         busy_cycles;
        bit         seen;
        model(a, b, eb, ee, elat);
        @(negedge clk);
        bus.digit1 = a;
        bus.digit0 = b;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.digit1  = 4'h0;
        bus.digit0  = 4'h0;
        chk({tag, ".busy_after_start"}, 32'(bus.busy), 32'd1);
        lat = 0;
        busy_cycles = 1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) seen = 1'b1;
            else if (bus.busy) busy_cycles++;
        end
        chk({tag, ".done_seen"}, 32'(seen), 32'd1);
        chk({tag, ".latency"}, 32'(lat), 32'(elat));
        chk({tag, ".busy_cycles"}, 32'(busy_cycles), 32'(elat));
        chk({tag, ".busy_at_done"}, 32'(bus.busy), 32'd0);
        chk({tag, ".bin_out"}, 32'(bus.bin_out), 32'(eb));
        chk({tag, ".err"}, 32'(bus.err), 32'(ee));
        @(posedge clk);
        #1;
        chk({tag, ".done_one_cycle"}, 32'(bus.done), 32'd0);
        chk({tag, ".bin_held"}, 32'(bus.bin_out), 32'(eb));
    endtask

    initial begin
        int         done_cnt;
        int         first_done;
        int         second_done;
        logic [5:0] eb;
        logic       ee;
        int         elat;

        bus.start  = 1'b0;
        bus.digit1 = 4'h0;
        bus.digit0 = 4'h0;
        reset      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy", 32'(bus.busy), 32'd0);
        chk("reset.done", 32'(bus.done), 32'd0);
        chk("reset.bin_out", 32'(bus.bin_out), 32'd0);
        chk("reset.err", 32'(bus.err), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        convert(4'd4, 4'd5, "d45");
        convert(4'd0, 4'd0, "d00");
        convert(4'd5, 4'd9, "d59");
        convert(4'd6, 4'd0, "d60");
        convert(4'd9, 4'd9, "d99");
        convert(4'hA, 4'd3, "dA3");
        convert(4'd2, 4'hF, "d2F");

        // start held high: two results five clocks apart
        @(negedge clk);
        bus.digit1 = 4'd1;
        bus.digit0 = 4'd2;
        bus.start  = 1'b1;
        first_done = -1;
        second_done = -1;
        for (int c = 0; c < 14 && second_done < 0; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                if (first_done < 0) first_done = c;
                else second_done = c;
            end
        end
        bus.start = 1'b0;
        chk("held.first_done", 32'(first_done), 32'd4);
        chk("held.spacing", 32'(second_done - first_done), 32'd5);
        chk("held.bin_out", 32'(bus.bin_out), 32'd12);
        repeat (6) @(posedge clk);

        // re-pulse while busy is ignored
        @(negedge clk);
        bus.digit1 = 4'd3;
        bus.digit0 = 4'd7;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        @(negedge clk);
        bus.digit1 = 4'd1;
        bus.digit0 = 4'd1;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                done_cnt++;
                chk("repulse.bin_out", 32'(bus.bin_out), 32'd37);
            end
        end
        chk("repulse.done_count", 32'(done_cnt), 32'd1);

        // reset mid-conversion aborts without a done
        @(negedge clk);
        bus.digit1 = 4'd4;
        bus.digit0 = 4'd8;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset.busy", 32'(bus.busy), 32'd0);
        chk("midreset.done", 32'(bus.done), 32'd0);
        chk("midreset.bin_out", 32'(bus.bin_out), 32'd0);
        chk("midreset.err", 32'(bus.err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_cnt++;
        end
        chk("midreset.no_done", 32'(done_cnt), 32'd0);
        convert(4'd2, 4'd3, "d23");

        for (int r = 0; r < 40; r++) begin
            logic [3:0] a;
            logic [3:0] b;
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            if (r % 2 == 0) begin
                a = 4'($urandom_range(0, 9));
                b = 4'($urandom_range(0, 9));
            end
            model(a, b, eb, ee, elat);
            convert(a, b, $sformatf("rand%0d_%0d_%0d", r, a, b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire

// File: doc/bcd2_to_bin_conv.md
# bcd2_to_bin_conv

Sequential two-digit BCD-to-binary converter for the clock/timer datapath, the inverse of the binary-to-BCD display decoding used by the seconds/minutes counters. It accepts a tens digit and a units digit from the BCD source (RTC register read or keypad entry), validates them, and produces the binary count used to preload the 0–59 up/down counters. The interface is a start/done handshake with fixed latency. Results outside the legal range are flagged.

## Interface

Parameters:
- N, 6, width of `bin_out` in bits.
- MAX_VAL, 59, largest legal converted value.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  request conversion; sampled only in IDLE
- digit1  in  4  BCD tens digit
- digit0  in  4  BCD units digit
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse when the result is valid
- bin_out  out  N  converted binary value; held until the next `done`
- err  out  1  error flag for the last conversion; valid with `done` and held until the next `done`

## Operation

- FSM states: IDLE, CHECK, ADD2, ADD0, RANGE.
- **IDLE:**
  - When `start`=1, latch `digit1`/`digit0` into internal registers and go to CHECK.
  - Inputs are ignored after latching.
- **CHECK:**
  - If either latched nibble is >9, set `bin_out`=0, `err`=1, pulse `done`, and go to IDLE.
  - Otherwise set acc = d1<<3 and go to ADD2.
- **ADD2:** acc += d1<<1, then go to ADD0.
- **ADD0:** acc += d0, then go to RANGE.
- **RANGE:**
  - If acc ≤ MAX_VAL: `bin_out`=acc[N-1:0], `err`=0.
  - Otherwise: out-of-range behaviour per Configuration, with `err`=1.
  - Pulse `done` and go to IDLE.
- **Arithmetic:** the accumulator is 7 bits unsigned, so the maximum value 99 cannot overflow. Truncation to N bits happens only on the legal path.
- **`start` while busy:** ignored, with no queuing.
- **`start` held high:** a new conversion begins on the first edge after the state returns to IDLE.
- **`busy`:** equals (state ≠ IDLE).

## Timing

- **Reset values:** state=IDLE, `busy`=0, `done`=0, `bin_out`=0, `err`=0, acc=0, latched digits=0.
- **Reset mid-conversion:** the conversion is aborted, no `done` is produced, and all outputs return to reset values.
- **Normal path** (start sampled at edge k):
  - `busy` is high after edge k.
  - `done`, `bin_out` and `err` update at edge k+4.
  - `busy` falls at edge k+4.
  - Total latency: 4 clocks.
- **Invalid-nibble path:** `done`/`err` update at edge k+1 (latency 1 clock).
- **`done`:** high for exactly one cycle per accepted `start`.
- **Minimum start-to-start spacing:** 5 clocks on the normal path, 2 on the invalid-nibble path.

## Configuration

- **`BCD_SATURATE_EN` defined:** an out-of-range result (valid BCD, acc > MAX_VAL) gives `bin_out`=MAX_VAL and `err`=1.
- **`BCD_SATURATE_EN` undefined:** an out-of-range result gives `bin_out`=0 and `err`=1.
- The invalid-nibble behaviour is identical in both builds.

## Structure

- Shared package:
  - FSM state encoding.
  - Constants `BCD_DIGIT_MAX`=9 and `BCD2_ACC_W`=7.
  - Default `MAX_VAL` values for seconds/minutes (59) and hours (23).
- One natural sub-module: `bcd_nibble_check`, a combinational validity check of one nibble, instantiated twice.
- FSM and accumulator stay in the top module.

## Test plan

- digit1=4, digit0=5, start pulse → after 4 clocks `done`=1 for 1 cycle, `bin_out`=45, `err`=0; `busy` high for 4 cycles.
- Boundaries 0/0 → 0, 5/9 → 59, both `err`=0; back-to-back starts with `start` held high → two `done` pulses 5 clocks apart.
- 6/0 → `err`=1; `bin_out`=0 (default build) or 59 (`BCD_SATURATE_EN`); 9/9 → same with no overflow.
- digit1=4'hA, digit0=3 → `done` 1 clock after start, `err`=1, `bin_out`=0; digit0=4'hF is handled likewise.
- `start` re-pulsed at k+2 with different digits → ignored; the result matches the first digits and only one `done` is produced.
- `reset` asserted at k+2 → `busy`/`done`/`err`/`bin_out`=0 immediately with no `done` pulse; a following conversion of 2/3 gives 23.
